// File: rtl/morse_encoder_pkg.sv
// Shared definitions for the Morse transmit path: FSM state encodings,
// symbol strobe encoding, gap/mark lengths in units and code-entry layout.
package morse_encoder_pkg;

    // Encoder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_GAP  = 3'd2,
        ST_CGAP = 3'd3,
        ST_WGAP = 3'd4
    } state_t;

    // Symbol encoding shared with the symbol-to-character path.
    typedef enum logic [1:0] {
        SYM_DOT        = 2'd0,
        SYM_DASH       = 2'd1,
        SYM_CHAR_SPACE = 2'd2,
        SYM_WORD_SPACE = 2'd3
    } sym_t;

    // Durations in Morse time units.
    localparam logic [2:0] UNITS_DOT  = 3'd1;
    localparam logic [2:0] UNITS_DASH = 3'd3;
    localparam logic [2:0] UNITS_GAP  = 3'd1;
    localparam logic [2:0] UNITS_CGAP = 3'd3;
    localparam logic [2:0] UNITS_WGAP = 3'd7;

    // Code-entry field widths.
    localparam int LEN_W = 3;
    localparam int PAT_W = 5;

    // One lookup result. Symbols go MSB-first from pat[len-1], 1 = dash.
    // A valid entry with len 0 is the word-space character.
    typedef struct packed {
        logic             valid;
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pat;
    } code_t;

    function automatic code_t mk_code(input logic [LEN_W-1:0] len,
                                      input logic [PAT_W-1:0] pat);
        code_t c;
        c.valid = 1'b1;
        c.len   = len;
        c.pat   = pat;
        return c;
    endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character stream handshake into the Morse encoder (valid/ready).
interface morse_encoder_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/morse_code_rom.sv
// Combinational ASCII -> Morse code lookup. Lower case folds to upper case;
// anything outside A-Z, 0-9 and space returns valid = 0.
module morse_code_rom
    import morse_encoder_pkg::*;
(
    input  logic [7:0] i_char,
    output code_t      o_code
);

    logic [7:0] w_upper;

    // Fold a-z onto A-Z so one table serves both cases.
    always_comb begin
        w_upper = i_char;
        if (i_char >= 8'h61 && i_char <= 8'h7a) begin
            w_upper = i_char - 8'h20;
        end
    end

    // Code table; pattern bits are right-aligned, first symbol is pat[len-1].
    always_comb begin
        o_code = '0;
        case (w_upper)
            8'h20: o_code = mk_code(3'd0, 5'b00000); // word space
            8'h41: o_code = mk_code(3'd2, 5'b00001); // A .-
            8'h42: o_code = mk_code(3'd4, 5'b01000); // B -...
            8'h43: o_code = mk_code(3'd4, 5'b01010); // C -.-.
            8'h44: o_code = mk_code(3'd3, 5'b00100); // D -..
            8'h45: o_code = mk_code(3'd1, 5'b00000); // E .
            8'h46: o_code = mk_code(3'd4, 5'b00010); // F ..-.
            8'h47: o_code = mk_code(3'd3, 5'b00110); // G --.
            8'h48: o_code = mk_code(3'd4, 5'b00000); // H ....
            8'h49: o_code = mk_code(3'd2, 5'b00000); // I ..
            8'h4a: o_code = mk_code(3'd4, 5'b00111); // J .---
            8'h4b: o_code = mk_code(3'd3, 5'b00101); // K -.-
            8'h4c: o_code = mk_code(3'd4, 5'b00100); // L .-..
            8'h4d: o_code = mk_code(3'd2, 5'b00011); // M --
            8'h4e: o_code = mk_code(3'd2, 5'b00010); // N -.
            8'h4f: o_code = mk_code(3'd3, 5'b00111); // O ---
            8'h50: o_code = mk_code(3'd4, 5'b00110); // P .--.
            8'h51: o_code = mk_code(3'd4, 5'b01101); // Q --.-
            8'h52: o_code = mk_code(3'd3, 5'b00010); // R .-.
            8'h53: o_code = mk_code(3'd3, 5'b00000); // S ...
            8'h54: o_code = mk_code(3'd1, 5'b00001); // T -
            8'h55: o_code = mk_code(3'd3, 5'b00001); // U ..-
            8'h56: o_code = mk_code(3'd4, 5'b00001); // V ...-
            8'h57: o_code = mk_code(3'd3, 5'b00011); // W .--
            8'h58: o_code = mk_code(3'd4, 5'b01001); // X -..-
            8'h59: o_code = mk_code(3'd4, 5'b01011); // Y -.--
            8'h5a: o_code = mk_code(3'd4, 5'b01100); // Z --..
            8'h30: o_code = mk_code(3'd5, 5'b11111); // 0 -----
            8'h31: o_code = mk_code(3'd5, 5'b01111); // 1 .----
            8'h32: o_code = mk_code(3'd5, 5'b00111); // 2 ..---
            8'h33: o_code = mk_code(3'd5, 5'b00011); // 3 ...--
            8'h34: o_code = mk_code(3'd5, 5'b00001); // 4 ....-
            8'h35: o_code = mk_code(3'd5, 5'b00000); // 5 .....
            8'h36: o_code = mk_code(3'd5, 5'b10000); // 6 -....
            8'h37: o_code = mk_code(3'd5, 5'b11000); // 7 --...
            8'h38: o_code = mk_code(3'd5, 5'b11100); // 8 ---..
            8'h39: o_code = mk_code(3'd5, 5'b11110); // 9 ----.
            default: o_code = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmit path: accepts ASCII characters and produces timed key
// output plus one-cycle symbol strobes. All outputs except char_ready and
// busy are registered; the first MARK/WGAP cycle follows the accept edge.
module morse_encoder
    import morse_encoder_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    morse_encoder_if.slave  s_char,
    output logic            key_out,
    output logic            dot_out,
    output logic            dash_out,
    output logic            char_space_out,
    output logic            word_space_out,
    output logic            err_out,
    output logic            busy
);

    // Timer reload value for n units; the multiply stays at CNT_W width.
    function automatic logic [CNT_W-1:0] unit_load(input logic [2:0] n);
        return CNT_W'(n) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] mark_load(input logic is_dash);
        return unit_load(is_dash ? UNITS_DASH : UNITS_DOT);
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_timer;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_idx;
    logic               r_key;
    logic               r_dot;
    logic               r_dash;
    logic               r_cs;
    logic               r_ws;
    logic               r_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic               w_dot_nxt;
    logic               w_dash_nxt;
    logic               w_cs_nxt;
    logic               w_ws_nxt;
    logic               w_err_nxt;

    code_t              w_code;
    logic [LEN_W-1:0]   w_first_idx;
    logic               w_first_dash;
    logic               w_next_dash;
    logic               w_accept;
    logic               w_timer_zero;

    morse_code_rom u_rom (
        .i_char (s_char.char_in),
        .o_code (w_code)
    );

    // Ready only in IDLE, not during the error-pulse cycle and never in reset.
    assign s_char.char_ready = (r_state == ST_IDLE) & ~r_err & ~rst;
    assign busy              = (r_state != ST_IDLE);

    assign w_accept     = s_char.char_valid & s_char.char_ready;
    assign w_timer_zero = (r_timer == '0);
    assign w_first_idx  = w_code.len - 3'd1;
    assign w_first_dash = w_code.pat[w_first_idx];
    assign w_next_dash  = r_pat[r_idx];

    assign key_out        = r_key;
    assign dot_out        = r_dot;
    assign dash_out       = r_dash;
    assign char_space_out = r_cs;
    assign word_space_out = r_ws;
    assign err_out        = r_err;

    // Next-state, timer reload and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_dot_nxt   = 1'b0;
        w_dash_nxt  = 1'b0;
        w_cs_nxt    = 1'b0;
        w_ws_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_code.valid) begin
                        w_err_nxt = 1'b1;
                    end else if (w_code.len == '0) begin
                        w_state_nxt = ST_WGAP;
                        w_timer_nxt = unit_load(UNITS_WGAP);
                        w_ws_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_MARK;
                        w_pat_nxt   = w_code.pat;
                        w_idx_nxt   = w_first_idx;
                        w_timer_nxt = mark_load(w_first_dash);
                        w_dot_nxt   = ~w_first_dash;
                        w_dash_nxt  = w_first_dash;
                    end
                end
            end
            ST_MARK: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end else if (r_idx != '0) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = unit_load(UNITS_GAP);
                    w_idx_nxt   = r_idx - 3'd1;
                end else begin
                    w_state_nxt = ST_CGAP;
                    w_timer_nxt = unit_load(UNITS_CGAP);
                    w_cs_nxt    = 1'b1;
                end
            end
            ST_GAP: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_MARK;
                    w_timer_nxt = mark_load(w_next_dash);
                    w_dot_nxt   = ~w_next_dash;
                    w_dash_nxt  = w_next_dash;
                end
            end
            ST_CGAP, ST_WGAP: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Control state, timer and registered outputs; reset aborts any character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_key   <= 1'b0;
            r_dot   <= 1'b0;
            r_dash  <= 1'b0;
            r_cs    <= 1'b0;
            r_ws    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_key   <= (w_state_nxt == ST_MARK);
            r_dot   <= w_dot_nxt;
            r_dash  <= w_dash_nxt;
            r_cs    <= w_cs_nxt;
            r_ws    <= w_ws_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Latched symbol pattern; only read outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        r_pat <= w_pat_nxt;
    end

endmodule
